write_buffer_mp: RTL and testbench

Posted write buffer between the direct-mapped cache's main-memory port and the main memory (mem_prin).
- Cache write-backs are absorbed in 1 cycle and drained to memory in the background.
- Cache block-fill reads go to memory ahead of queued writes, unless a queued write targets the same word. In that case the buffer drains fully before the read (RAW safe).
- Single outstanding transaction on the memory side.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 88 ++++++++
 rtl/write_buffer_mp.sv | 171 +++++++++++++++++
 tb/tb_write_buffer_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the posted write buffer.
// One-hot FSM encodings and entry field widths.
package wb_pkg;

    localparam int WORD_LSB = 2;
    localparam int STRB_W   = 4;

    typedef enum logic [3:0] {
        C_IDLE     = 4'b0001,
        C_RD_PEND  = 4'b0010,
        C_RD_DRAIN = 4'b0100,
        C_RD_WAIT  = 4'b1000
    } c_state_e;

    typedef enum logic [2:0] {
        M_IDLE  = 3'b001,
        M_WRITE = 3'b010,
        M_READ  = 3'b100
    } m_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular write-entry store with occupancy tracking and a
// parallel word-address match across all occupied entries.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int WA_W  = ADDR_W - WORD_LSB,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [WA_W-1:0]   push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [STRB_W-1:0] push_strb,
    input  logic              pop,
    output logic [WA_W-1:0]   head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [STRB_W-1:0] head_strb,
    input  logic [WA_W-1:0]   match_addr,
    output logic              any_match,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  count_nxt,
    output logic              full
);

    logic [WA_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [STRB_W-1:0] strb_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic [PTR_W-1:0] off;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Entry payload needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
            strb_q[wr_ptr_q] <= push_strb;
        end
    end

    // Entry i is live when its distance from the head is below count.
    always_comb begin
        any_match = 1'b0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if ((CNT_W'(off) < count_q) && (addr_q[i] == match_addr))
                any_match = 1'b1;
        end
    end

    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign head_strb = strb_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;
    assign full      = full_q;

endmodule

// File: rtl/write_buffer_mp.sv
// Posted write buffer between cache and main memory: writes drain in
// the background, reads bypass queued writes unless a word conflicts.
module write_buffer_mp
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              c_valid,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [3:0]        c_wstrb,
    output logic              c_ready,
    output logic [DATA_W-1:0] c_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              buf_empty,
    output logic              buf_full
);

    localparam int WA_W  = ADDR_W - WORD_LSB;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    c_state_e          c_state_q, c_state_d;
    m_state_e          m_state_q, m_state_d;
    logic              c_ready_q, c_ready_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic              m_valid_q, m_valid_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [3:0]        m_wstrb_q, m_wstrb_d;
    logic              buf_empty_q, buf_empty_d;

    logic              push, pop, any_match, full, req, done;
    logic [WA_W-1:0]   head_addr;
    logic [DATA_W-1:0] head_data;
    logic [3:0]        head_strb;
    logic [CNT_W-1:0]  count, count_nxt;

    wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .push_addr  (c_addr[ADDR_W-1:WORD_LSB]),
        .push_data  (c_wdata),
        .push_strb  (c_wstrb),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .head_strb  (head_strb),
        .match_addr (c_addr[ADDR_W-1:WORD_LSB]),
        .any_match  (any_match),
        .count      (count),
        .count_nxt  (count_nxt),
        .full       (full)
    );

    // A request in its own c_ready cycle is ignored to avoid re-accepting it.
    assign req  = c_valid && !c_ready_q;
    assign done = m_valid_q && m_ready;

    always_comb begin
        c_state_d = c_state_q;
        m_state_d = m_state_q;
        c_ready_d = 1'b0;
        c_rdata_d = c_rdata_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        push      = 1'b0;
        pop       = 1'b0;

        unique case (c_state_q)
            C_IDLE: begin
                if (req && (|c_wstrb) && !full) begin
                    push      = 1'b1;
                    c_ready_d = 1'b1;
                end else if (req && !(|c_wstrb)) begin
                    c_state_d = any_match ? C_RD_DRAIN : C_RD_PEND;
                end
            end
            C_RD_WAIT: begin
                if (m_state_q == M_READ && done) begin
                    c_state_d = C_IDLE;
                    c_ready_d = 1'b1;
                    c_rdata_d = m_rdata;
                end
            end
            C_RD_PEND, C_RD_DRAIN: ;
            default: c_state_d = C_IDLE;
        endcase

        unique case (m_state_q)
            M_IDLE: begin
                if (c_state_q == C_RD_PEND ||
                    (c_state_q == C_RD_DRAIN && count == '0)) begin
                    m_state_d = M_READ;
                    c_state_d = C_RD_WAIT;
                    m_valid_d = 1'b1;
                    m_addr_d  = {c_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
                    m_wdata_d = '0;
                    m_wstrb_d = '0;
                end else if (count != '0) begin
                    m_state_d = M_WRITE;
                    m_valid_d = 1'b1;
                    m_addr_d  = {head_addr, {WORD_LSB{1'b0}}};
                    m_wdata_d = head_data;
                    m_wstrb_d = head_strb;
                end
            end
            M_WRITE: begin
                if (done) begin
                    pop       = 1'b1;
                    m_valid_d = 1'b0;
                    m_state_d = M_IDLE;
                end
            end
            M_READ: begin
                if (done) begin
                    m_valid_d = 1'b0;
                    m_state_d = M_IDLE;
                end
            end
            default: m_state_d = M_IDLE;
        endcase

        buf_empty_d = (count_nxt == '0) && (m_state_d == M_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_state_q   <= C_IDLE;
            m_state_q   <= M_IDLE;
            c_ready_q   <= 1'b0;
            c_rdata_q   <= '0;
            m_valid_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            buf_empty_q <= 1'b1;
        end else begin
            c_state_q   <= c_state_d;
            m_state_q   <= m_state_d;
            c_ready_q   <= c_ready_d;
            c_rdata_q   <= c_rdata_d;
            m_valid_q   <= m_valid_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
            buf_empty_q <= buf_empty_d;
        end
    end

    assign c_ready   = c_ready_q;
    assign c_rdata   = c_rdata_q;
    assign m_valid   = m_valid_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign buf_empty = buf_empty_q;
    assign buf_full  = full;

endmodule

// File: tb/tb_write_buffer_mp.sv
// Directed bench for write_buffer_mp with a latency-modelled memory
// and a log of memory transactions in completion order.
module tb_write_buffer_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        c_valid = 1'b0;
    logic [31:0] c_addr = '0;
    logic [31:0] c_wdata = '0;
    logic [3:0]  c_wstrb = '0;
    logic        c_ready;
    logic [31:0] c_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        buf_empty;
    logic        buf_full;

    int total = 0;
    int bad   = 0;
    int mcnt  = 0;

    logic [31:0] mem [0:1023];
    logic [32:0] log_q [$];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    write_buffer_mp #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .c_valid   (c_valid),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_wstrb   (c_wstrb),
        .c_ready   (c_ready),
        .c_rdata   (c_rdata),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .buf_empty (buf_empty),
        .buf_full  (buf_full)
    );

    function automatic logic [31:0] init_val(int i);
        return 32'h5A00_0000 + 32'(i);
    endfunction

    // Memory: one-cycle m_ready pulse 8 (read) / 15 (write) cycles after m_valid.
    always @(negedge clk) begin
        int idx;
        if (!resetn) begin
            mcnt    = 0;
            m_ready = 1'b0;
        end else if (m_ready) begin
            m_ready = 1'b0;
            mcnt    = 0;
        end else if (m_valid) begin
            mcnt++;
            if (mcnt >= ((m_wstrb != 4'h0) ? 15 : 8)) begin
                m_ready = 1'b1;
                idx     = int'(m_addr[11:2]);
                m_rdata = mem[idx];
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
                log_q.push_back({m_wstrb != 4'h0, m_addr});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cache_req(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd,
                             output int lat);
        @(negedge clk);
        while (c_ready) @(negedge clk);
        c_valid = 1'b1;
        c_addr  = a;
        c_wdata = d;
        c_wstrb = s;
        lat     = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!c_ready && lat < 600);
        chk("req timeout", !c_ready, 0);
        rd      = c_rdata;
        c_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!buf_empty && n < 2000);
        chk("drain timeout", !buf_empty, 0);
    endtask

    task automatic check_log(input string tag);
        chk({tag, " n"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < log_q.size()) chk(tag, log_q[i], exp_q[i]);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;

        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst c_ready", c_ready, 0);
        chk("rst c_rdata", c_rdata, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst buf_empty", buf_empty, 1);
        chk("rst buf_full", buf_full, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Single write on an empty buffer
        cache_req(32'h100, 32'hDEADBEEF, 4'hF, rd, lat);
        chk("t1 lat", lat, 1);
        @(posedge clk);
        #1;
        chk("t1 m_valid", m_valid, 1);
        chk("t1 m_addr", m_addr, 32'h100);
        chk("t1 m_wdata", m_wdata, 32'hDEADBEEF);
        chk("t1 m_wstrb", m_wstrb, 4'hF);
        wait_idle();
        chk("t1 mem", mem[32'h40], 32'hDEADBEEF);
        chk("t1 empty", buf_empty, 1);

        // Five writes into a four-deep buffer
        log_q.delete();
        for (int i = 0; i < 4; i++) begin
            cache_req(32'h200 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, rd, lat);
            chk("t2 lat", lat, 1);
        end
        chk("t2 full", buf_full, 1);
        cache_req(32'h210, 32'hA4, 4'hF, rd, lat);
        chk("t2 w5 stalled", lat > 1, 1);
        chk("t2 drained first", log_q.size(), 1);
        wait_idle();
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 32'h200 + 32'(4*i)});
        check_log("t2 order");
        chk("t2 mem5", mem[32'h84], 32'hA4);

        // Read bypasses queued writes to other words
        log_q.delete();
        cache_req(32'h300, 32'h3000, 4'hF, rd, lat);
        cache_req(32'h304, 32'h3004, 4'hF, rd, lat);
        cache_req(32'h308, 32'h3008, 4'hF, rd, lat);
        cache_req(32'h400, 32'h0, 4'h0, rd, lat);
        chk("t3 rdata", rd, init_val(32'h100));
        wait_idle();
        exp_q.delete();
        exp_q.push_back({1'b1, 32'h300});
        exp_q.push_back({1'b0, 32'h400});
        exp_q.push_back({1'b1, 32'h304});
        exp_q.push_back({1'b1, 32'h308});
        check_log("t3 order");

        // Read of a queued word waits for the full drain
        log_q.delete();
        cache_req(32'h504, 32'h5004, 4'hF, rd, lat);
        cache_req(32'h508, 32'h5008, 4'hF, rd, lat);
        cache_req(32'h500, 32'h12345678, 4'hF, rd, lat);
        cache_req(32'h500, 32'h0, 4'h0, rd, lat);
        chk("t4 rdata", rd, 32'h12345678);
        wait_idle();
        exp_q.delete();
        exp_q.push_back({1'b1, 32'h504});
        exp_q.push_back({1'b1, 32'h508});
        exp_q.push_back({1'b1, 32'h500});
        exp_q.push_back({1'b0, 32'h500});
        check_log("t4 order");

        // Reset while a write is in flight
        cache_req(32'h600, 32'hCAFEF00D, 4'hF, rd, lat);
        repeat (3) @(posedge clk);
        #1;
        chk("t5 in flight", m_valid, 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("t5 m_valid", m_valid, 0);
        chk("t5 m_addr", m_addr, 0);
        chk("t5 m_wdata", m_wdata, 0);
        chk("t5 m_wstrb", m_wstrb, 0);
        chk("t5 c_ready", c_ready, 0);
        chk("t5 c_rdata", c_rdata, 0);
        chk("t5 empty", buf_empty, 1);
        chk("t5 full", buf_full, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        log_q.delete();
        cache_req(32'h600, 32'h0, 4'h0, rd, lat);
        chk("t5 rdata", rd, init_val(32'h180));
        wait_idle();
        exp_q.delete();
        exp_q.push_back({1'b0, 32'h600});
        check_log("t5 order");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
